// File: rtl/wb_gpio_arbiter_pkg.sv
// Shared types for the Wishbone GPIO arbiter: FSM state encoding and index-width helper.
package wb_gpio_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_TMO   = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  // Width of a master index; never below 1 so a 2-master build still has a real bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_gpio_arbiter_if.sv
// Bundle of the shared-master side and the single-slave side of the GPIO arbiter.
interface wb_gpio_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0]    m_cyc_i;
  logic [NUM_MASTERS-1:0]    m_stb_i;
  logic [NUM_MASTERS-1:0]    m_we_i;
  logic [4*NUM_MASTERS-1:0]  m_sel_i;
  logic [32*NUM_MASTERS-1:0] m_adr_i;
  logic [32*NUM_MASTERS-1:0] m_dat_i;
  logic [31:0]               m_dat_o;
  logic [NUM_MASTERS-1:0]    m_ack_o;
  logic [NUM_MASTERS-1:0]    m_err_o;
  logic                      s_cyc_o;
  logic                      s_stb_o;
  logic                      s_we_o;
  logic [3:0]                s_sel_o;
  logic [31:0]               s_adr_o;
  logic [31:0]               s_dat_o;
  logic [31:0]               s_dat_i;
  logic                      s_ack_i;
  logic                      s_err_i;

  // Arbiter view: slave to the masters, master to the GPIO slave.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i, s_err_i
  );

  // Environment view: the requesting masters plus the GPIO register slave.
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i, s_err_i
  );
endinterface

// File: rtl/wb_gpio_arbiter_rr_priority_select.sv
// Round-robin pick: one-hot grant for the first requester after index `last`, cyclically.
import wb_gpio_arbiter_pkg::*;

module rr_priority_select #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt
);
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IW'((int'(last) + off) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_gpio_arbiter.sv
// Round-robin Wishbone arbiter in front of the GPIO register slave; grant held for a whole cyc.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
import wb_gpio_arbiter_pkg::*;

module wb_gpio_arbiter #(
  parameter int NUM_MASTERS = 2
`ifdef WB_ARB_TIMEOUT_EN
  ,parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_gpio_arbiter_if.slave       bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   busy_o
);
  localparam int N  = NUM_MASTERS;
  localparam int IW = idx_w(NUM_MASTERS);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [N-1:0]  gnt_sel;
  logic [IW-1:0] owner_idx;
  logic          own_cyc, own_stb, own_we;
  logic [3:0]    own_sel;
  logic [31:0]   own_adr, own_dat;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wdog_q, wdog_d;
  logic          stall;
`endif

  rr_priority_select #(.N(N), .IW(IW)) u_rr (
    .req  (bus.m_cyc_i),
    .last (last_q),
    .gnt  (gnt_sel)
  );

  // Owner's request fields, selected by the registered one-hot grant.
  always_comb begin
    owner_idx = '0;
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_sel   = '0;
    own_adr   = '0;
    own_dat   = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_q[k]) begin
        owner_idx = IW'(k);
        own_cyc   = bus.m_cyc_i[k];
        own_stb   = bus.m_stb_i[k];
        own_we    = bus.m_we_i[k];
        own_sel   = bus.m_sel_i[4*k +: 4];
        own_adr   = bus.m_adr_i[32*k +: 32];
        own_dat   = bus.m_dat_i[32*k +: 32];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(N - 1);
`ifdef WB_ARB_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  assign stall  = (state_q == ST_BUSY) && own_stb && !bus.s_ack_i && !bus.s_err_i;
  assign wdog_d = stall ? wdog_q + 1'b1 : '0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.m_cyc_i) begin
          state_d = ST_BUSY;
          grant_d = gnt_sel;
        end
      end
      ST_BUSY: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_idx;
        end
`ifdef WB_ARB_TIMEOUT_EN
        // Counter reaches TIMEOUT_CYCLES-1 on this edge.
        else if (stall && wdog_q == TW'(TIMEOUT_CYCLES - 2)) begin
          state_d = ST_TMO;
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_TMO: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_idx;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_sel_o = '0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    if (state_q == ST_BUSY) begin
      bus.s_cyc_o = own_cyc;
      bus.s_stb_o = own_stb;
      bus.s_we_o  = own_we;
      bus.s_sel_o = own_sel;
      bus.s_adr_o = own_adr;
      bus.s_dat_o = own_dat;
      bus.m_ack_o = grant_q & {N{bus.s_ack_i}};
      bus.m_err_o = grant_q & {N{bus.s_err_i}};
    end
`ifdef WB_ARB_TIMEOUT_EN
    if (state_q == ST_TMO) bus.m_err_o = grant_q;
`endif
  end

  assign bus.m_dat_o = bus.s_dat_i;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_wb_gpio_arbiter.sv
// Directed self-checking bench for wb_gpio_arbiter with two masters.
module tb_wb_gpio_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       busy;
  int         checks   = 0;
  int         failures = 0;

  wb_gpio_arbiter_if #(.NUM_MASTERS(2)) bus ();

  wb_gpio_arbiter #(
    .NUM_MASTERS(2)
`ifdef WB_ARB_TIMEOUT_EN
    ,.TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .grant_o  (grant),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_masters();
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_sel_i = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    bus.s_dat_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    clear_masters();
    do_reset();
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_scyc", bus.s_cyc_o, 1'b0);
    chk("rst_ack", bus.m_ack_o, 2'b00);
    chk("rst_err", bus.m_err_o, 2'b00);

    // Single master write
    bus.m_cyc_i[0] = 1'b1; bus.m_stb_i[0] = 1'b1; bus.m_we_i[0] = 1'b1;
    bus.m_sel_i[3:0] = 4'hF; bus.m_adr_i[31:0] = 32'h14; bus.m_dat_i[31:0] = 32'hA5A5_0001;
    #1 chk("t1_scyc_lat0", bus.s_cyc_o, 1'b0);
    tick();
    chk("t1_scyc", bus.s_cyc_o, 1'b1);
    chk("t1_grant", grant, 2'b01);
    chk("t1_adr", bus.s_adr_o, 32'h14);
    chk("t1_dat", bus.s_dat_o, 32'hA5A5_0001);
    chk("t1_we_sel", {bus.s_we_o, bus.s_sel_o}, 5'h1F);
    chk("t1_noack", bus.m_ack_o, 2'b00);
    bus.s_ack_i = 1'b1;
    #1 chk("t1_ack", bus.m_ack_o, 2'b01);
    tick();
    bus.s_ack_i = 1'b0;
    bus.m_cyc_i[0] = 1'b0; bus.m_stb_i[0] = 1'b0;
    #1 chk("t1_grant_hold", grant, 2'b01);
    tick();
    chk("t1_rel_grant", grant, 2'b00);
    chk("t1_rel_scyc", bus.s_cyc_o, 1'b0);
    clear_masters();

    // Contention from reset: m0 first, one idle clock, then m1
    do_reset();
    bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
    bus.m_adr_i = {32'h30, 32'h20};
    tick();
    chk("t2_grant0", grant, 2'b01);
    chk("t2_adr0", bus.s_adr_o, 32'h20);
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h0000_1234;
    #1 chk("t2_ack0", bus.m_ack_o, 2'b01);
    chk("t2_rdat", bus.m_dat_o, 32'h0000_1234);
    tick();
    bus.s_ack_i = 1'b0;
    bus.m_cyc_i[0] = 1'b0; bus.m_stb_i[0] = 1'b0;
    tick();
    chk("t2_gap_scyc", bus.s_cyc_o, 1'b0);
    chk("t2_gap_grant", grant, 2'b00);
    tick();
    chk("t2_grant1", grant, 2'b10);
    chk("t2_adr1", bus.s_adr_o, 32'h30);
    bus.s_ack_i = 1'b1;
    #1 chk("t2_ack1", bus.m_ack_o, 2'b10);
    tick();
    clear_masters();
    tick();

    // Fairness: both request continuously, 3 accesses per ownership
    do_reset();
    bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
    tick();
    for (int j = 0; j < 4; j++) begin
      logic [1:0] exp_g;
      exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("t3_grant%0d", j), grant, exp_g);
      bus.s_ack_i = 1'b1;
      for (int a = 0; a < 3; a++) begin
        #1 chk($sformatf("t3_ack%0d_%0d", j, a), bus.m_ack_o, exp_g);
        tick();
      end
      bus.s_ack_i = 1'b0;
      bus.m_cyc_i = bus.m_cyc_i & ~exp_g;
      bus.m_stb_i = bus.m_stb_i & ~exp_g;
      tick();
      chk($sformatf("t3_gap%0d", j), bus.s_cyc_o, 1'b0);
      bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
      tick();
    end
    clear_masters();
    tick();
    tick();

    // Atomic read-modify-write by m1 while m0 waits
    do_reset();
    bus.m_cyc_i[1] = 1'b1; bus.m_stb_i[1] = 1'b1; bus.m_adr_i[63:32] = 32'h24;
    tick();
    chk("t4_grant1", grant, 2'b10);
    bus.m_cyc_i[0] = 1'b1; bus.m_stb_i[0] = 1'b1; bus.m_adr_i[31:0] = 32'h50;
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h0000_00F0;
    #1 chk("t4_rd_adr", bus.s_adr_o, 32'h24);
    chk("t4_rd_ack", bus.m_ack_o, 2'b10);
    chk("t4_rd_dat", bus.m_dat_o, 32'h0000_00F0);
    tick();
    bus.s_ack_i = 1'b0;
    bus.m_we_i[1] = 1'b1; bus.m_dat_i[63:32] = 32'h0000_00F1;
    #1 chk("t4_wr_adr", bus.s_adr_o, 32'h24);
    chk("t4_wr_we", bus.s_we_o, 1'b1);
    chk("t4_wr_dat", bus.s_dat_o, 32'h0000_00F1);
    tick();
    chk("t4_hold_grant", grant, 2'b10);
    bus.s_ack_i = 1'b1;
    #1 chk("t4_wr_ack", bus.m_ack_o, 2'b10);
    tick();
    bus.s_ack_i = 1'b0;
    bus.m_cyc_i[1] = 1'b0; bus.m_stb_i[1] = 1'b0; bus.m_we_i[1] = 1'b0;
    tick();
    chk("t4_gap", bus.s_cyc_o, 1'b0);
    tick();
    chk("t4_grant0", grant, 2'b01);
    chk("t4_adr0", bus.s_adr_o, 32'h50);
    clear_masters();
    tick();
    tick();

    // Reset while busy aborts the cycle
    do_reset();
    bus.m_cyc_i[0] = 1'b1; bus.m_stb_i[0] = 1'b1; bus.m_adr_i[31:0] = 32'h08;
    tick();
    chk("t5_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    bus.s_ack_i = 1'b1;
    #1 chk("t5_scyc", bus.s_cyc_o, 1'b0);
    chk("t5_grant", grant, 2'b00);
    chk("t5_noack", bus.m_ack_o, 2'b00);
    rst = 1'b0;
    clear_masters();
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog: slave never acks
    do_reset();
    bus.m_cyc_i[0] = 1'b1; bus.m_stb_i[0] = 1'b1;
    tick();
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("t6_noerr%0d", c), {bus.s_cyc_o, bus.m_err_o}, 3'b100);
      tick();
    end
    chk("t6_err", bus.m_err_o, 2'b01);
    chk("t6_tmo_scyc", bus.s_cyc_o, 1'b0);
    tick();
    chk("t6_drain", {bus.s_cyc_o, bus.m_err_o, busy}, 4'b0001);
    bus.m_cyc_i[0] = 1'b0; bus.m_stb_i[0] = 1'b0;
    tick();
    chk("t6_idle", busy, 1'b0);
    clear_masters();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
